// File: rtl/idct_sched_pkg.sv
// Shared constants and FSM state type for the idct_sched coefficient scheduler.
package idct_pkg;

    localparam int unsigned DW         = 16;
    localparam int unsigned OW         = 24;
    localparam int unsigned LANES      = 4;
    localparam int unsigned DP_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/idct_sched_fifo.sv
// Result FIFO for idct_sched: DEPTH entries, head presented combinationally from
// registered storage, asynchronous active-high reset of the control state.
module idct_sched_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The datapath cannot stall, so a push into a full FIFO means the credit loop is broken.
    assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/idct_sched.sv
// idct_sched: skews 4-lane coefficient vectors onto the IDCT datapath and buffers
// its results under credit flow control. Optional counters: IDCT_SCHED_STATS_EN.
module idct_sched
    import idct_pkg::LANES, idct_pkg::DP_LATENCY, idct_pkg::state_t,
           idct_pkg::ST_IDLE, idct_pkg::ST_BUSY, idct_pkg::ST_DRAIN;
#(
    parameter int unsigned DW    = idct_pkg::DW,
    parameter int unsigned OW    = idct_pkg::OW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic                flush,
    output logic [DW-1:0]       d_in_1,
    output logic [DW-1:0]       d_in_2,
    output logic [DW-1:0]       d_in_3,
    output logic [DW-1:0]       d_in_4,
    input  logic [OW-1:0]       dp_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out_data,
    output logic                busy
`ifdef IDCT_SCHED_STATS_EN
   ,output logic [31:0]         stat_issued,
    output logic [31:0]         stat_stall
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("idct_sched: DEPTH must lie in 2..16");
    end

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         credit;
    logic [CW-1:0]         credit_nxt;
    logic [DP_LATENCY-1:0] vld;
    logic                  accept;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DW-1:0]         lane_out [LANES];

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld <= {vld[DP_LATENCY-2:0], accept};
        end
    end

    // Lane k is a k+1 stage delay line; idle slots carry zero so lanes without a token read 0.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [k:0][DW-1:0] pipe;
        logic [DW-1:0]      head;

        assign head = accept ? in_data[k*DW +: DW] : '0;

        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge reset) begin
                if (reset) pipe <= '0;
                else       pipe <= head;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge reset) begin
                if (reset) pipe <= '0;
                else       pipe <= {pipe[k-1:0], head};
            end
        end

        assign lane_out[k] = pipe[k];
    end

    assign d_in_1 = lane_out[0];
    assign d_in_2 = lane_out[1];
    assign d_in_3 = lane_out[2];
    assign d_in_4 = lane_out[3];

    idct_sched_fifo #(
        .WIDTH (OW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld[DP_LATENCY-1]),
        .push_data (dp_result),
        .pop       (pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid  = !fifo_empty;
    assign credit_nxt = credit - CW'(accept) + CW'(pop);

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_DRAIN;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state_nxt = ST_BUSY;
                ST_BUSY:  if (!accept && vld == '0 && fifo_empty) state_nxt = ST_IDLE;
                ST_DRAIN: if (vld == '0 && fifo_empty) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // in_ready and busy are registered from next-state values so both read 0 throughout reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            credit   <= CW'(DEPTH);
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            in_ready <= (credit_nxt != '0) && (state_nxt != ST_DRAIN);
            busy     <= (state_nxt != ST_IDLE);
        end
    end

    assert property (@(posedge clk) disable iff (reset) accept |-> credit != '0);
    assert property (@(posedge clk) disable iff (reset) fifo_full |-> credit == '0);

`ifdef IDCT_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && stat_issued != '1) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (in_valid && !in_ready && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idct_sched.sv
// Scoreboard bench for idct_sched: a weighted-sum stand-in datapath, a lane-skew
// monitor and an in-order result scoreboard, driven by directed vectors.
module tb_idct_sched;

    localparam int unsigned DW       = 16;
    localparam int unsigned OW       = 24;
    // Streaming one vector per cycle keeps DP_LATENCY+1 results outstanding, so DEPTH must exceed 4.
    localparam int unsigned TB_DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] in_data;
    logic            flush;
    logic [DW-1:0]   d_in_1, d_in_2, d_in_3, d_in_4;
    logic [OW-1:0]   dp_result;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            busy;
`ifdef IDCT_SCHED_STATS_EN
    logic [31:0]     stat_issued;
    logic [31:0]     stat_stall;
`endif

    always #5 clk = ~clk;

    idct_sched #(
        .DW    (DW),
        .OW    (OW),
        .DEPTH (TB_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .d_in_1    (d_in_1),
        .d_in_2    (d_in_2),
        .d_in_3    (d_in_3),
        .d_in_4    (d_in_4),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef IDCT_SCHED_STATS_EN
       ,.stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    int              checks = 0;
    int              errors = 0;
    int unsigned     acc_cnt = 0;
    logic [OW-1:0]   sb_q [$];
    logic [3:0]      hv;
    logic [4*DW-1:0] hd [4];
    logic [DW-1:0]   lanes [4];
    logic [OW-1:0]   s1, s2, s3;
    logic [4*DW-1:0] b2b [8];

    assign lanes[0] = d_in_1;
    assign lanes[1] = d_in_2;
    assign lanes[2] = d_in_3;
    assign lanes[3] = d_in_4;

    function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [OW-1:0] dp_model(input logic [4*DW-1:0] v);
        logic [OW-1:0] c0, c1, c2, c3;
        c0 = OW'(v[DW-1:0]);
        c1 = OW'(v[2*DW-1:DW]);
        c2 = OW'(v[3*DW-1:2*DW]);
        c3 = OW'(v[4*DW-1:3*DW]);
        return c0 + OW'(3) * c1 + OW'(5) * c2 + OW'(7) * c3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'((sb_q.size() == 0) && !busy), 32'd1);
    endtask

    // Stand-in datapath: accumulates the skewed lanes so dp_result at slot 4 is a weighted sum.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= OW'(d_in_1);
            s2 <= s1 + OW'(3) * OW'(d_in_2);
            s3 <= s2 + OW'(5) * OW'(d_in_3);
        end
    end
    assign dp_result = s3 + OW'(7) * OW'(d_in_4);

    // Stimulus side of the scoreboard: record accepted vectors and push their expected results.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hv <= '0;
            for (int i = 0; i < 4; i++) hd[i] <= '0;
            sb_q.delete();
        end else begin
            hv    <= {hv[2:0], in_valid && in_ready};
            hd[0] <= in_data;
            hd[1] <= hd[0];
            hd[2] <= hd[1];
            hd[3] <= hd[2];
            if (in_valid && in_ready) begin
                sb_q.push_back(dp_model(in_data));
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("lane%0d", k + 1), 32'(lanes[k]),
                    hv[k] ? 32'(hd[k][k*DW +: DW]) : 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d, expected no result", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int n;

        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        b2b[0] = pack4(10, 20, 30, 40);
        b2b[1] = pack4(0, 0, 0, 1);
        b2b[2] = pack4(65535, 0, 0, 0);
        b2b[3] = pack4(1, 1, 1, 1);
        b2b[4] = pack4(100, 200, 300, 400);
        b2b[5] = pack4(7, 0, 7, 0);
        b2b[6] = pack4(0, 9, 0, 9);
        b2b[7] = pack4(1234, 5678, 91, 12);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d_in_1", 32'(d_in_1), 32'd0);
        chk("rst_d_in_4", 32'(d_in_4), 32'd0);
`ifdef IDCT_SCHED_STATS_EN
        chk("rst_stat_issued", stat_issued, 32'd0);
        chk("rst_stat_stall", stat_stall, 32'd0);
`endif
        reset = 1'b0;
        tick();
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Single vector {1,2,3,4}: lane skew and result latency.
        in_data  = pack4(1, 2, 3, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_d_in_1", 32'(d_in_1), 32'd1);
        tick();
        chk("single_d_in_2", 32'(d_in_2), 32'd2);
        tick();
        chk("single_d_in_3", 32'(d_in_3), 32'd3);
        tick();
        chk("single_d_in_4", 32'(d_in_4), 32'd4);
        chk("single_out_valid_T4", 32'(out_valid), 32'd0);
        tick();
        chk("single_out_valid_T5", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'd50);
        out_ready = 1'b1;
        drain("single_drain", 20);

        // Eight back-to-back vectors with the sink always ready.
        base = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            in_data  = b2b[i];
            in_valid = 1'b1;
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("b2b_accepts", acc_cnt - base, 32'd8);
        drain("b2b_drain", 40);

        // Flush: first accept alone, second accept in the same cycle as flush.
        out_ready = 1'b0;
        base      = acc_cnt;
        in_data   = pack4(5, 6, 7, 8);
        in_valid  = 1'b1;
        tick();
        in_data = pack4(9, 10, 11, 12);
        flush   = 1'b1;
        chk("flush_cycle_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_data  = '0;
        chk("flush_accepts", acc_cnt - base, 32'd2);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_hold_in_ready", 32'(in_ready), 32'd0);
        end
        chk("flush_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            chk("flush_pop_in_ready", 32'(in_ready), 32'd0);
            tick();
            n++;
        end
        chk("flush_results_out", 32'(sb_q.size()), 32'd0);
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk("flush_busy_done", 32'(busy), 32'd0);
        chk("flush_in_ready_back", 32'(in_ready), 32'd1);

        // Backpressure: sink stalled, source offers every cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("bp_in_ready_start", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        base      = acc_cnt;
        in_valid  = 1'b1;
        for (int i = 0; i < int'(TB_DEPTH) + 6; i++) begin
            in_data = pack4(i + 1, 2 * i, 300 - i, 17);
            tick();
        end
        chk("bp_accepts", acc_cnt - base, TB_DEPTH);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
`ifdef IDCT_SCHED_STATS_EN
        chk("bp_stat_issued", stat_issued, TB_DEPTH);
        chk("bp_stat_stall", stat_stall, 32'd6);
`endif
        base      = acc_cnt;
        in_data   = pack4(42, 43, 44, 45);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (6) tick();
        chk("bp_one_pop_one_accept", acc_cnt - base, 32'd1);
        chk("bp_in_ready_relow", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        drain("bp_drain", 60);

        // Reset with three tokens in flight and two results queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data  = pack4(11 * (i + 1), 22, 33, 44 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
        chk("pre_reset_d_in_4", 32'(d_in_4), 32'd44 + 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_d_in_1", 32'(d_in_1), 32'd0);
        chk("mid_reset_d_in_2", 32'(d_in_2), 32'd0);
        chk("mid_reset_d_in_3", 32'(d_in_3), 32'd0);
        chk("mid_reset_d_in_4", 32'(d_in_4), 32'd0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        base     = acc_cnt;
        in_valid = 1'b1;
        in_data  = pack4(3, 1, 4, 1);
        for (int i = 0; i < int'(TB_DEPTH) + 4; i++) tick();
        chk("post_reset_credit", acc_cnt - base, TB_DEPTH);
        chk("post_reset_in_ready_low", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        drain("post_reset_drain", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idct_sched.md
IDCT_SCHED -- requirements
Module: idct_sched

Interface
REQ-001 Parameter DW, default 16, coefficient lane width.
REQ-002 Parameter OW, default 24, datapath result width.
REQ-003 Parameter DEPTH, default 4, output FIFO entries; legal range 2..16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  coefficient vector offered.
REQ-007 in_ready  output  1  vector accepted when in_valid && in_ready.
REQ-008 in_data  input  4*DW  coefficients c0..c3, c0 in the LSBs.
REQ-009 flush  input  1  single-cycle pulse requesting a drain.
REQ-010 d_in_1 .. d_in_4  output  DW each  skewed lanes to the 4-point IDCT datapath.
REQ-011 dp_result  input  OW  datapath d_out.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 out_data  output  OW  head of the output FIFO.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 A vector accepted at cycle T SHALL drive c0 on d_in_1 at T+1, c1 on d_in_2 at T+2, c2 on d_in_3 at T+3 and c3 on d_in_4 at T+4, each through registers.
REQ-017 A lane with no valid token in its skew slot SHALL be driven with 0.
REQ-018 A 4-bit valid shift register SHALL track tokens; dp_result SHALL be written to the output FIFO in the cycle the token reaches slot 4 (T+4), and out_valid SHALL be asserted from T+5.
REQ-019 Back-to-back accepts SHALL be supported: one vector per cycle, with no bubbles inserted.
REQ-020 A credit counter SHALL equal DEPTH minus (FIFO occupancy + tokens in flight); in_ready = (credit != 0) && state != DRAIN.
REQ-021 Credit SHALL decrement on accept, increment on pop, and stay unchanged when both occur in the same cycle.
REQ-022 The datapath never stalls, so the output FIFO SHALL never overflow; an overflow is a design error, flagged by an assertion.
REQ-023 Output FIFO full SHALL give credit 0 and in_ready 0; output FIFO empty SHALL give out_valid 0.
REQ-024 FSM states and transitions:
- IDLE -> BUSY on accept.
- BUSY -> IDLE when no tokens are in flight and the FIFO is empty.
- Any state -> DRAIN on flush.
- DRAIN -> IDLE when the pipeline is empty and the FIFO is empty.
REQ-025 Flush SHALL NOT discard data: tokens in flight SHALL complete, and results SHALL still be popped normally.
REQ-026 A flush arriving in the same cycle as an accept SHALL let the accept complete, then enter DRAIN.
REQ-027 Results SHALL leave the block in acceptance order, with out_data bit-exact to dp_result.

Reset
REQ-028 On reset the block SHALL take these values:
- state IDLE, credit DEPTH.
- FIFO empty, valid shift register cleared.
- d_in_1..d_in_4 = 0; out_valid, busy and in_ready = 0.
REQ-029 in_ready SHALL go to 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tokens and FIFO contents immediately (asynchronous).

Configuration
REQ-031 Macro IDCT_SCHED_STATS_EN defined: the block SHALL add outputs stat_issued (32-bit count of accepted vectors) and stat_stall (32-bit count of cycles with in_valid && !in_ready), both reset to 0 and saturating.
REQ-032 Macro IDCT_SCHED_STATS_EN undefined: those ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package idct_pkg SHALL hold:
- constants DW, OW, LANES=4, DP_LATENCY=4 (accept to result capture);
- the FSM state enum type.
REQ-034 The output FIFO SHALL be a separate sub-module, idct_sched_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-035 Single vector {1,2,3,4} accepted at cycle 10 -> d_in_1=1 @11, d_in_2=2 @12, d_in_3=3 @13, d_in_4=4 @14; out_valid @15 with out_data = dp_result sampled @14.
REQ-036 8 back-to-back vectors with out_ready=1 -> 8 results in order, in_ready constantly 1, zero stall cycles.
REQ-037 DEPTH=4, out_ready=0, continuous in_valid -> exactly 4 accepts, then in_ready=0; one pop restores exactly one accept.
REQ-038 Flush pulsed with 2 tokens in flight -> in_ready=0 until both results are popped, busy=0 afterwards, no data lost.
REQ-039 Reset asserted with 3 tokens in flight and 2 FIFO entries -> out_valid=0 and all lanes 0 immediately; credit=DEPTH after release.
REQ-040 With IDCT_SCHED_STATS_EN, the REQ-037 stimulus held 6 further cycles -> stat_issued=4, stat_stall=6.
